ov7670_pixel_capture: RTL and testbench
=======================================

// Module: ov7670_pixel_capture
// PURPOSE
//  Camera-side capture stage. Samples the OV7670 byte stream (vsync/href/d).
//  Pairs RGB565 bytes into 12-bit RGB444 pixels.
//  Issues one frame-buffer write (addr/dout/we) per pixel.
//  Its pixel-write strobe drives the enable of the downstream pixel-address counter and frame RAM.
// PARAMETERS
//  ADDR_W      17     width of frame-buffer address
//  MAX_PIX     76800  pixels per frame (320x240); writes at addr >= MAX_PIX are suppressed
//  CONTINUOUS  1      1: re-arm for next frame automatically; 0: single snapshot per en pulse
// PORTS
//  clk         in   1       camera pixel clock (pclk); all logic on rising edge
//  reset       in   1       synchronous, active-high
//  en          in   1       capture request; sampled in IDLE only
//  vsync       in   1       camera vsync, high = vertical blanking
//  href        in   1       camera href, high = valid bytes on d
//  d           in   8       camera data byte
//  addr        out  ADDR_W  frame-buffer write address
//  dout        out  12      pixel {R[3:0],G[3:0],B[3:0]}
//  we          out  1       one-cycle write strobe, qualifies addr/dout
//  frame_done  out  1       one-cycle pulse at end of a captured frame
//  busy        out  1       high in ARM and CAPTURE states
// BEHAVIOUR
//  - Input stage: vsync/href/d registered once (vsync_q, href_q, d_q); all decisions use _q.
//  - Reset: state=IDLE; addr=0, dout=0, we=0, frame_done=0, busy=0; byte phase=0; input regs=0.
//  - FSM:
//      IDLE    -> ARM when en=1.
//      ARM     -> waits for vsync_q falling edge (1->0); on it -> CAPTURE, pixel count=0, phase=0.
//      CAPTURE -> on vsync_q rising edge: pulse frame_done.
//                 Then -> ARM if CONTINUOUS=1, else -> IDLE.
//  - Byte pairing, CAPTURE with href_q=1:
//      phase 0: latch d_q as hi byte; phase<=1.
//      phase 1: form pixel, phase<=0.
//  - Pixel format (hi=R4..R0 G5..G3, lo=G2..G0 B4..B0):
//      dout = {hi[7:4], hi[2:0], lo[7], lo[4:1]}.
//  - Pixel write (registered):
//      we=1 the cycle after lo is taken from d_q (2 clk after lo byte at pins); addr=pixel count.
//      Pixel count increments after each we.
//      If count >= MAX_PIX, we stays 0 and count holds (no wrap into frame start).
//  - href_q falling with phase=1: orphan hi byte discarded, phase<=0, no write.
//  - href_q=0: phase forced 0; no writes.
//  - addr/dout hold their last value when we=0; we and frame_done default 0 each cycle.
//  - vsync_q rising while a pixel write is pending: that write still issues the same cycle.
//    frame_done is asserted together with it.
//  - en ignored outside IDLE; en held high with CONTINUOUS=0 restarts on the next cycle in IDLE.
//  - reset mid-frame: immediate return to IDLE on the next edge.
//    Partial frame abandoned; no frame_done.
//  - Widths: count is ADDR_W bits, compared unsigned against MAX_PIX; MAX_PIX must be <= 2**ADDR_W.
// STRUCTURE
//  - Shared package cam_pkg:
//      state encoding IDLE/ARM/CAPTURE (2 bits)
//      PIX_W=12, CAM_BYTE_W=8
//      default QVGA constants (320, 240, 76800)
//  - One sub-module: pixel_addr_counter.
//      ADDR_W-bit counter; sync active-high clear and increment enable; saturate flag at MAX_PIX.
//  - Top holds input regs, FSM, byte-phase flag, pixel packer, output regs.
// TESTING
//  1 reset held 3 clk during a streaming frame -> addr=0, we=0, busy=0, frame_done=0.
//    No write for 2 clk after release.
//  2 en=1; vsync 1->0; href=1 with bytes 0xF8,0x1F ->
//    one we with addr=0, dout=0xF0F 2 clk after 0x1F at pins; busy=1.
//  3 one line of 4 pixel pairs, href low, line of 2 pairs ->
//    we addrs 0..5 in order, no gaps, no extra strobes.
//  4 href drops after 3 bytes (odd count) -> exactly 1 write.
//    Next line restarts at phase 0, with next addr=1.
//  5 MAX_PIX=4, stream 6 pixels then vsync 0->1 ->
//    writes at addr 0..3 only; one frame_done pulse.
//    CONTINUOUS=0: busy=0 the cycle after; CONTINUOUS=1: busy stays 1.
//  6 reset asserted mid-line at addr=10 -> state IDLE.
//    With en=1 and a new frame, first write at addr=0; no frame_done for the aborted frame.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared types and constants for the OV7670 capture path: FSM encoding,
// bus widths, QVGA frame geometry and the RGB565 -> RGB444 packer.
package cam_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      CAPTURE = 2'd2
   } cam_state_t;

   localparam int PIX_W      = 12;
   localparam int CAM_BYTE_W = 8;
   localparam int QVGA_W     = 320;
   localparam int QVGA_H     = 240;
   localparam int QVGA_PIX   = 76800;

   // hi = R4..R0 G5..G3, lo = G2..G0 B4..B0; keep the top 4 bits of each channel
   function automatic logic [PIX_W-1:0] rgb565_to_444(input logic [CAM_BYTE_W-1:0] hi,
                                                      input logic [CAM_BYTE_W-1:0] lo);
      return {hi[7:4], hi[2:0], lo[7], lo[4:1]};
   endfunction

endpackage

// File: rtl/pixel_addr_counter.sv
// Frame-buffer pixel address counter: synchronous clear, increment enable,
// and a saturation flag that blocks counting once MAX_PIX is reached.
module pixel_addr_counter #(
   parameter int ADDR_W  = 17,
   parameter int MAX_PIX = 76800
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              inc,
   output logic [ADDR_W-1:0] count,
   output logic              sat
);

   // one extra bit so MAX_PIX == 2**ADDR_W is representable
   localparam logic [ADDR_W:0] MAX_VAL = (ADDR_W+1)'(MAX_PIX);

   assign sat = ({1'b0, count} >= MAX_VAL);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (inc && !sat) begin
         count <= count + ADDR_W'(1);
      end
   end

endmodule

// File: rtl/ov7670_pixel_capture.sv
// OV7670 capture stage: registers the camera byte stream, pairs RGB565 bytes
// into RGB444 pixels and issues one frame-buffer write per pixel.
module ov7670_pixel_capture
   import cam_pkg::*;
#(
   parameter int ADDR_W     = 17,
   parameter int MAX_PIX    = QVGA_PIX,
   parameter int CONTINUOUS = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  vsync,
   input  logic                  href,
   input  logic [CAM_BYTE_W-1:0] d,
   output logic [ADDR_W-1:0]     addr,
   output logic [PIX_W-1:0]      dout,
   output logic                  we,
   output logic                  frame_done,
   output logic                  busy
);

   cam_state_t            state;
   logic                  vsync_q;
   logic                  vsync_prev;
   logic                  href_q;
   logic [CAM_BYTE_W-1:0] d_q;
   logic                  phase;
   logic [CAM_BYTE_W-1:0] hi_byte;
   logic [ADDR_W-1:0]     pix_count;
   logic                  pix_sat;
   logic                  vsync_fall;
   logic                  vsync_rise;
   logic                  cnt_clear;

   assign vsync_fall = vsync_prev && !vsync_q;
   assign vsync_rise = !vsync_prev && vsync_q;
   assign cnt_clear  = (state == ARM) && vsync_fall;

   // the write strobe itself advances the address for the next pixel
   pixel_addr_counter #(
      .ADDR_W  (ADDR_W),
      .MAX_PIX (MAX_PIX)
   ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (cnt_clear),
      .inc   (we),
      .count (pix_count),
      .sat   (pix_sat)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         vsync_q    <= 1'b0;
         vsync_prev <= 1'b0;
         href_q     <= 1'b0;
         d_q        <= '0;
      end else begin
         vsync_q    <= vsync;
         vsync_prev <= vsync_q;
         href_q     <= href;
         d_q        <= d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         addr       <= '0;
         dout       <= '0;
         we         <= 1'b0;
         frame_done <= 1'b0;
         busy       <= 1'b0;
         phase      <= 1'b0;
         hi_byte    <= '0;
      end else begin
         we         <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (en) begin
                  state <= ARM;
                  busy  <= 1'b1;
               end
            end
            ARM: begin
               if (vsync_fall) begin
                  state <= CAPTURE;
                  phase <= 1'b0;
               end
            end
            CAPTURE: begin
               // an unpaired hi byte at the end of a line is simply dropped
               if (href_q) begin
                  if (!phase) begin
                     hi_byte <= d_q;
                     phase   <= 1'b1;
                  end else begin
                     phase <= 1'b0;
                     if (!pix_sat) begin
                        we   <= 1'b1;
                        addr <= pix_count;
                        dout <= rgb565_to_444(hi_byte, d_q);
                     end
                  end
               end else begin
                  phase <= 1'b0;
               end
               if (vsync_rise) begin
                  frame_done <= 1'b1;
                  if (CONTINUOUS != 0) begin
                     state <= ARM;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               phase <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// Directed bench for ov7670_pixel_capture: three instances (QVGA continuous,
// 4-pixel continuous, 4-pixel snapshot) checked every cycle against a frame-level model.
module tb_ov7670_pixel_capture;

   logic        clk = 1'b0;
   logic        reset, en, vsync, href;
   logic [7:0]  d;
   logic [16:0] addr_0, addr_1, addr_2;
   logic [11:0] dout_0, dout_1, dout_2;
   logic        we_0, we_1, we_2, fd_0, fd_1, fd_2, busy_0, busy_1, busy_2;

   always #5 clk = ~clk;

   ov7670_pixel_capture #(.ADDR_W(17), .MAX_PIX(76800), .CONTINUOUS(1)) u0 (
      .clk(clk), .reset(reset), .en(en), .vsync(vsync), .href(href), .d(d),
      .addr(addr_0), .dout(dout_0), .we(we_0), .frame_done(fd_0), .busy(busy_0));
   ov7670_pixel_capture #(.ADDR_W(17), .MAX_PIX(4), .CONTINUOUS(1)) u1 (
      .clk(clk), .reset(reset), .en(en), .vsync(vsync), .href(href), .d(d),
      .addr(addr_1), .dout(dout_1), .we(we_1), .frame_done(fd_1), .busy(busy_1));
   ov7670_pixel_capture #(.ADDR_W(17), .MAX_PIX(4), .CONTINUOUS(0)) u2 (
      .clk(clk), .reset(reset), .en(en), .vsync(vsync), .href(href), .d(d),
      .addr(addr_2), .dout(dout_2), .we(we_2), .frame_done(fd_2), .busy(busy_2));

   int n_cmp = 0;
   int n_bad = 0;
   int tick_n = 0;

   // model state: mode 0 = waiting for en, 1 = waiting for frame start, 2 = in frame
   int          maxp [3] = '{76800, 4, 4};
   bit          cont [3] = '{1'b1, 1'b1, 1'b0};
   int          m_mode [3];
   bit          m_have [3];
   logic [7:0]  m_hi [3];
   int          m_n [3];
   logic [16:0] e_addr [3];
   logic [11:0] e_dout [3];
   bit          e_we [3], e_fd [3], e_busy [3];
   bit          m_pvs, m_prevvs, m_phr;
   logic [7:0]  m_pd;

   int          wr_n [3], fd_n [3], last_addr [3], last_wtick [3], fd_tick [3];
   int          log_n;
   int          log_addr [64];
   logic [11:0] log_dout [64];
   int          log_tick [64];
   bit          log_busy [64];

   function automatic logic [11:0] pack(input logic [7:0] hi, input logic [7:0] lo);
      int r5, g6, b5;
      r5 = int'(hi) / 8;
      g6 = (int'(hi) % 8) * 8 + int'(lo) / 32;
      b5 = int'(lo) % 32;
      return 12'((r5 / 2) * 256 + (g6 / 4) * 16 + (b5 / 2));
   endfunction

   task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s inst%0d tick%0d: got %0h want %0h", nm, i, tick_n, act, exp);
      end
   endtask

   task automatic model_step();
      bit vfall, vrise;
      if (reset) begin
         for (int i = 0; i < 3; i++) begin
            m_mode[i] = 0; m_have[i] = 1'b0; m_hi[i] = 8'h00; m_n[i] = 0;
            e_addr[i] = 17'd0; e_dout[i] = 12'h000;
            e_we[i] = 1'b0; e_fd[i] = 1'b0; e_busy[i] = 1'b0;
         end
         m_pvs = 1'b0; m_prevvs = 1'b0; m_phr = 1'b0; m_pd = 8'h00;
      end else begin
         vfall = m_prevvs && !m_pvs;
         vrise = !m_prevvs && m_pvs;
         for (int i = 0; i < 3; i++) begin
            e_we[i] = 1'b0;
            e_fd[i] = 1'b0;
            if (m_mode[i] == 0) begin
               if (en) m_mode[i] = 1;
            end else if (m_mode[i] == 1) begin
               if (vfall) begin
                  m_mode[i] = 2; m_n[i] = 0; m_have[i] = 1'b0;
               end
            end else begin
               if (!m_phr) begin
                  m_have[i] = 1'b0;
               end else if (!m_have[i]) begin
                  m_hi[i] = m_pd; m_have[i] = 1'b1;
               end else begin
                  m_have[i] = 1'b0;
                  if (m_n[i] < maxp[i]) begin
                     e_we[i] = 1'b1;
                     e_addr[i] = 17'(m_n[i]);
                     e_dout[i] = pack(m_hi[i], m_pd);
                     m_n[i]++;
                  end
               end
               if (vrise) begin
                  e_fd[i] = 1'b1;
                  m_mode[i] = cont[i] ? 1 : 0;
               end
            end
            e_busy[i] = (m_mode[i] != 0);
         end
         m_prevvs = m_pvs; m_pvs = vsync; m_phr = href; m_pd = d;
      end
   endtask

   task automatic compare_all();
      logic [16:0] aa; logic [11:0] ad; logic aw, af, ab;
      for (int i = 0; i < 3; i++) begin
         case (i)
            0:       begin aa = addr_0; ad = dout_0; aw = we_0; af = fd_0; ab = busy_0; end
            1:       begin aa = addr_1; ad = dout_1; aw = we_1; af = fd_1; ab = busy_1; end
            default: begin aa = addr_2; ad = dout_2; aw = we_2; af = fd_2; ab = busy_2; end
         endcase
         chk("we", i, 32'(aw), 32'(e_we[i]));
         chk("frame_done", i, 32'(af), 32'(e_fd[i]));
         chk("busy", i, 32'(ab), 32'(e_busy[i]));
         chk("addr", i, 32'(aa), 32'(e_addr[i]));
         chk("dout", i, 32'(ad), 32'(e_dout[i]));
         if (aw) begin
            wr_n[i]++; last_addr[i] = int'(aa); last_wtick[i] = tick_n;
            if (i == 0 && log_n < 64) begin
               log_addr[log_n] = int'(aa); log_dout[log_n] = ad;
               log_tick[log_n] = tick_n; log_busy[log_n] = ab; log_n++;
            end
         end
         if (af) begin
            fd_n[i]++; fd_tick[i] = tick_n;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      tick_n++;
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic drive(input bit vs, input bit hr, input logic [7:0] dd);
      vsync = vs; href = hr; d = dd;
      tick();
   endtask

   task automatic clear_logs();
      log_n = 0;
      for (int i = 0; i < 3; i++) begin
         wr_n[i] = 0; fd_n[i] = 0; last_addr[i] = -1; last_wtick[i] = -1; fd_tick[i] = -1;
      end
   endtask

   task automatic send_line(input int n, input int base);
      for (int k = 0; k < n; k++) drive(1'b0, 1'b1, 8'((base + k * 37) % 256));
   endtask

   // vsync blanking pulse, then active region begins
   task automatic frame_start();
      for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 8'h00);
      clear_logs();
      for (int k = 0; k < 2; k++) drive(1'b0, 1'b0, 8'h00);
   endtask

   task automatic pulse_en();
      en = 1'b1;
      drive(1'b0, 1'b0, 8'h00);
      en = 1'b0;
   endtask

   initial begin
      int t_lo;
      reset = 1'b1; en = 1'b0; vsync = 1'b0; href = 1'b1; d = 8'h55;
      clear_logs();

      // 1: reset during a streaming frame
      for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, 8'(8'h40 + k));
      chk("rst_addr", 0, 32'(addr_0), 32'd0);
      chk("rst_we", 0, 32'(we_0), 32'd0);
      chk("rst_busy", 0, 32'(busy_0), 32'd0);
      chk("rst_fd", 0, 32'(fd_0), 32'd0);
      reset = 1'b0;
      for (int k = 0; k < 2; k++) begin
         drive(1'b0, 1'b1, 8'(8'h80 + k));
         chk("post_rst_we", 0, 32'(we_0), 32'd0);
      end

      // 2: first pixel 0xF8,0x1F
      pulse_en();
      frame_start();
      drive(1'b0, 1'b1, 8'hF8);
      drive(1'b0, 1'b1, 8'h1F);
      t_lo = tick_n;
      for (int k = 0; k < 4; k++) drive(1'b0, 1'b0, 8'h00);
      chk("p1_count", 0, 32'(log_n), 32'd1);
      chk("p1_addr", 0, 32'(log_addr[0]), 32'd0);
      chk("p1_dout", 0, 32'(log_dout[0]), 32'h0F0F);
      chk("p1_latency", 0, 32'(log_tick[0]), 32'(t_lo + 1));
      chk("p1_busy", 0, 32'(log_busy[0]), 32'd1);

      // 3: line of 4 pairs, gap, line of 2 pairs
      frame_start();
      drive(1'b0, 1'b1, 8'h12);
      drive(1'b0, 1'b1, 8'h34);
      send_line(6, 8'h50);
      for (int k = 0; k < 2; k++) drive(1'b0, 1'b0, 8'h00);
      send_line(4, 8'h70);
      for (int k = 0; k < 4; k++) drive(1'b0, 1'b0, 8'h00);
      chk("l3_count", 0, 32'(log_n), 32'd6);
      for (int k = 0; k < 6; k++) chk("l3_addr", 0, 32'(log_addr[k]), 32'(k));
      chk("l3_dout0", 0, 32'(log_dout[0]), 32'h014A);
      chk("l3_sat_count", 1, 32'(wr_n[1]), 32'd4);
      chk("l3_idle_count", 2, 32'(wr_n[2]), 32'd0);

      // 4: odd byte count, orphan dropped
      frame_start();
      drive(1'b0, 1'b1, 8'hA0);
      drive(1'b0, 1'b1, 8'hB1);
      drive(1'b0, 1'b1, 8'hC2);
      for (int k = 0; k < 2; k++) drive(1'b0, 1'b0, 8'h00);
      drive(1'b0, 1'b1, 8'h0F);
      drive(1'b0, 1'b1, 8'hF0);
      for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 8'h00);
      chk("odd_count", 0, 32'(log_n), 32'd2);
      chk("odd_dout0", 0, 32'(log_dout[0]), 32'h0A18);
      chk("odd_addr1", 0, 32'(log_addr[1]), 32'd1);
      chk("odd_dout1", 0, 32'(log_dout[1]), 32'h00F8);

      // 5: six pixels into 4-pixel frame, vsync rises with last lo byte
      pulse_en();
      frame_start();
      send_line(11, 8'h60);
      drive(1'b1, 1'b1, 8'h99);
      for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 8'h00);
      chk("sat_wr", 1, 32'(wr_n[1]), 32'd4);
      chk("sat_last", 1, 32'(last_addr[1]), 32'd3);
      chk("sat_wr", 2, 32'(wr_n[2]), 32'd4);
      chk("sat_last", 2, 32'(last_addr[2]), 32'd3);
      chk("sat_fd", 1, 32'(fd_n[1]), 32'd1);
      chk("sat_fd", 2, 32'(fd_n[2]), 32'd1);
      chk("snap_busy", 2, 32'(busy_2), 32'd0);
      chk("cont_busy", 1, 32'(busy_1), 32'd1);
      chk("full_wr", 0, 32'(wr_n[0]), 32'd6);
      chk("full_fd", 0, 32'(fd_n[0]), 32'd1);
      chk("fd_with_we", 0, 32'(fd_tick[0]), 32'(last_wtick[0]));

      // 6: reset mid-line after addr 10
      frame_start();
      send_line(22, 8'h10);
      drive(1'b0, 1'b1, 8'hAA);
      chk("pre_rst_addr", 0, 32'(last_addr[0]), 32'd10);
      reset = 1'b1;
      drive(1'b0, 1'b1, 8'hBB);
      drive(1'b1, 1'b1, 8'hCC);
      chk("mid_rst_busy", 0, 32'(busy_0), 32'd0);
      chk("mid_rst_addr", 0, 32'(addr_0), 32'd0);
      reset = 1'b0;
      clear_logs();
      for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 8'h00);
      for (int k = 0; k < 2; k++) drive(1'b0, 1'b0, 8'h00);
      chk("abort_fd", 0, 32'(fd_n[0]), 32'd0);
      pulse_en();
      frame_start();
      send_line(4, 8'h21);
      for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 8'h00);
      chk("restart_count", 0, 32'(log_n), 32'd2);
      chk("restart_addr0", 0, 32'(log_addr[0]), 32'd0);
      chk("restart_fd", 0, 32'(fd_n[0]), 32'd0);
      for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 8'h00);
      chk("end_fd", 0, 32'(fd_n[0]), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
